// File: rtl/os_lane_assembler.sv
// Ordered-set lane assembler: frames COM-mode and block-mode ordered sets
// from deskewed multi-lane beats and presents them as one held output word.
module os_lane_assembler #(
  parameter int LANES = 16,
  parameter int SYM   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              gen,
  input  logic [4:0]              active_lanes,
  input  logic                    in_valid,
  input  logic [LANES*SYM*8-1:0]  in_data,
  input  logic                    block_start,
  input  logic [1:0]              sync_hdr,
  input  logic                    os_ready,
  output logic                    os_valid,
  output logic [LANES*128-1:0]    os_data,
  output logic [2:0]              os_type,
  output logic [4:0]              os_len,
  output logic                    os_lane_err,
  output logic                    overflow
);

  localparam int W = LANES * 128;

  localparam logic [2:0] T_UNK   = 3'd0;
  localparam logic [2:0] T_TS1   = 3'd1;
  localparam logic [2:0] T_TS2   = 3'd2;
  localparam logic [2:0] T_SKP   = 3'd3;
  localparam logic [2:0] T_EIOS  = 3'd4;
  localparam logic [2:0] T_FTS   = 3'd5;
  localparam logic [2:0] T_EIEOS = 3'd6;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state, state_n;
  logic [4:0]     fill, fill_n;
  logic [4:0]     cur_len, cur_len_n;
  logic [2:0]     cur_type, cur_type_n;
  logic [W-1:0]   asm_q, asm_n;
  logic [2:0]     gen_q;
  logic [4:0]     lanes_q;
  logic [LANES-1:0] lane_en;

  logic           done;
  logic [W-1:0]   done_data;
  logic [2:0]     done_type;
  logic [4:0]     done_len;
  logic           done_err;

  // Decode the configured width into a per-lane enable; unsupported widths fall back to one lane
  always_comb begin
    int n;
    n = 1;
    if ((active_lanes inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) && (int'(active_lanes) <= LANES))
      n = int'(active_lanes);
    lane_en = '0;
    for (int l = 0; l < LANES; l++) lane_en[l] = (l < n);
  end

  // Walk the beat symbol by symbol: lane 0 frames, all active lanes capture, completion snapshots the OS
  always_comb begin
    logic       com_mode;
    logic       blk_mode;
    logic [7:0] c;
    int         tidx;
    state_n    = state;
    fill_n     = fill;
    cur_len_n  = cur_len;
    cur_type_n = cur_type;
    asm_n      = asm_q;
    done       = 1'b0;
    done_data  = '0;
    done_type  = T_UNK;
    done_len   = 5'd0;
    done_err   = 1'b0;
    c          = 8'h00;
    tidx       = 0;
    com_mode   = (gen == 3'd1) || (gen == 3'd2);
    blk_mode   = (gen == 3'd3);

    if ((gen != gen_q) || (active_lanes != lanes_q)) begin
      state_n = IDLE;
      fill_n  = 5'd0;
    end

    if (in_valid && blk_mode && block_start) begin
      if (sync_hdr == 2'b01) begin
        state_n   = COLLECT;
        fill_n    = 5'd0;
        asm_n     = '0;
        cur_len_n = 5'd16;
        case (in_data[7:0])
          8'h1E:   cur_type_n = T_TS1;
          8'h2D:   cur_type_n = T_TS2;
          8'hAA:   cur_type_n = T_SKP;
          8'h66:   cur_type_n = T_EIOS;
          8'h00:   cur_type_n = T_EIEOS;
          default: cur_type_n = T_UNK;
        endcase
      end else begin
        state_n = IDLE;
        fill_n  = 5'd0;
      end
    end

    if (in_valid && (com_mode || blk_mode)) begin
      for (int s = 0; s < SYM; s++) begin
        c = in_data[s*8 +: 8];
        if (com_mode && (c == 8'hBC)) begin
          state_n    = COLLECT;
          fill_n     = 5'd0;
          asm_n      = '0;
          cur_len_n  = 5'd16;
          cur_type_n = T_UNK;
        end
        if (state_n == COLLECT) begin
          for (int l = 0; l < LANES; l++)
            if (lane_en[l]) asm_n[l*128 + 8*int'(fill_n) +: 8] = in_data[(l*SYM+s)*8 +: 8];
          if (com_mode && (fill_n == 5'd1)) begin
            case (c)
              8'h1C:   begin cur_len_n = 5'd4;  cur_type_n = T_SKP;  end
              8'h7C:   begin cur_len_n = 5'd4;  cur_type_n = T_EIOS; end
              8'h3C:   begin cur_len_n = 5'd4;  cur_type_n = T_FTS;  end
              default: begin cur_len_n = 5'd16; cur_type_n = T_UNK;  end
            endcase
          end
          if (com_mode && (fill_n == 5'd6) && (cur_len_n == 5'd16)) begin
            if (c == 8'h4A)      cur_type_n = T_TS1;
            else if (c == 8'h45) cur_type_n = T_TS2;
            else                 cur_type_n = T_UNK;
          end
          fill_n = fill_n + 5'd1;
          if (fill_n == cur_len_n) begin
            tidx = blk_mode ? 0 : ((cur_len_n == 5'd4) ? 1 : 6);
            done      = 1'b1;
            done_data = asm_n;
            done_type = cur_type_n;
            done_len  = cur_len_n;
            for (int l = 1; l < LANES; l++)
              if (lane_en[l] &&
                  ((asm_n[l*128 +: 8] != asm_n[7:0]) ||
                   (asm_n[l*128 + tidx*8 +: 8] != asm_n[tidx*8 +: 8])))
                done_err = 1'b1;
            state_n = IDLE;
            fill_n  = 5'd0;
          end
        end
      end
    end
  end

  // Framing state, fill count, partial OS buffer and last-seen configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fill     <= 5'd0;
      cur_len  <= 5'd0;
      cur_type <= T_UNK;
      asm_q    <= '0;
      gen_q    <= 3'd0;
      lanes_q  <= 5'd0;
    end else begin
      state    <= state_n;
      fill     <= fill_n;
      cur_len  <= cur_len_n;
      cur_type <= cur_type_n;
      asm_q    <= asm_n;
      gen_q    <= gen;
      lanes_q  <= active_lanes;
    end
  end

  // Output holding register: load when free or being consumed, otherwise drop and flag overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_valid    <= 1'b0;
      os_data     <= '0;
      os_type     <= 3'd0;
      os_len      <= 5'd0;
      os_lane_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (done) begin
      if (!os_valid || os_ready) begin
        os_valid    <= 1'b1;
        os_data     <= done_data;
        os_type     <= done_type;
        os_len      <= done_len;
        os_lane_err <= done_err;
      end else begin
        overflow <= 1'b1;
      end
    end else if (os_valid && os_ready) begin
      os_valid <= 1'b0;
    end
  end

endmodule

// File: doc/os_lane_assembler.md
OS_LANE_ASSEMBLER -- requirements
Module: os_lane_assembler

Interface
REQ-001 SHALL have parameter LANES, default 16, giving the maximum lane count (1,2,4,8,16).
REQ-002 SHALL have parameter SYM, default 4, giving the number of symbols per lane per beat (1,2,4).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port gen  input  3  link generation: 1 or 2 selects COM mode; 3 selects block mode; any other value causes beats to be ignored.
REQ-006 SHALL have port active_lanes  input  5  configured width, one of 1/2/4/8/16; other values are treated as 1.
REQ-007 SHALL have port in_valid  input  1  marks a beat as valid.
REQ-008 SHALL have port in_data  input  LANES*SYM*8  carries lane l, symbol s at bits [(l*SYM+s)*8 +: 8]; s=0 is the earliest symbol.
REQ-009 SHALL have port block_start  input  1  block mode only; the beat's symbol 0 is block symbol 0.
REQ-010 SHALL have port sync_hdr  input  2  block mode only; valid with block_start; 2'b01 is an ordered-set block.
REQ-011 SHALL have port os_ready  input  1  consumer accepts os_data.
REQ-012 SHALL have port os_valid  output  1  a completed ordered set is held.
REQ-013 SHALL have port os_data  output  LANES*128  carries lane l, OS symbol n at [l*128+n*8 +: 8].
REQ-014 SHALL have port os_type  output  3  0 UNK, 1 TS1, 2 TS2, 3 SKP, 4 EIOS, 5 FTS, 6 EIEOS.
REQ-015 SHALL have port os_len  output  5  ordered-set length in symbols (4 or 16).
REQ-016 SHALL have port os_lane_err  output  1  active lanes disagreed on symbol 0 or on the type symbol.
REQ-017 SHALL have port overflow  output  1  sticky flag: an ordered set completed while the output was held.

Function
REQ-018 Lanes SHALL be deskewed upstream; lane 0 alone determines framing, and all active lanes capture the same symbol positions.
REQ-019 In COM mode, a symbol of 0xBC on lane 0 while IDLE SHALL start assembly at that symbol position; symbols earlier in the beat are discarded.
REQ-020 In COM mode, symbol 1 SHALL fix the length:
- 0x1C: SKP, length 4
- 0x7C: EIOS, length 4
- 0x3C: FTS, length 4
- otherwise: length 16, typed at symbol 6 as 0x4A TS1, 0x45 TS2, else UNK.
REQ-021 In block mode, a beat with block_start=1 and sync_hdr=2'b01 SHALL start a 16-symbol assembly at symbol 0, typed by symbol 0 as 0x1E TS1, 0x2D TS2, 0xAA SKP, 0x66 EIOS, 0x00 EIEOS, else UNK; a block_start with any other sync_hdr SHALL abort assembly and return to IDLE.
REQ-022 The FSM SHALL have states IDLE -> COLLECT -> IDLE; a per-lane fill counter (0..16) SHALL advance by the number of captured symbols per valid beat.
REQ-023 Beats with in_valid=0 SHALL be ignored and SHALL leave state unchanged.
REQ-024 When the fill count reaches os_len within a beat, the OS SHALL complete, and os_valid SHALL assert on the next rising edge with os_data/os_type/os_len/os_lane_err registered; latency is 1 clock after the completing beat.
REQ-025 Symbols after the completing symbol in the same beat SHALL be rescanned for a new COM (COM mode), so that back-to-back ordered sets lose no symbols.
REQ-026 A COM on lane 0 during COLLECT (COM mode, before completion) SHALL discard the partial OS and restart at that position, with no output.
REQ-027 os_data symbols at or beyond os_len, and all inactive lanes, SHALL be zero.
REQ-028 os_valid/os_data SHALL remain stable until os_valid && os_ready; on that edge os_valid SHALL clear unless a new OS completes in the same cycle, in which case the new OS SHALL load and os_valid SHALL stay 1.
REQ-029 An OS completing while os_valid=1 and os_ready=0 SHALL be dropped, overflow SHALL set, and overflow SHALL clear only on reset.
REQ-030 A change of gen or active_lanes SHALL force IDLE and discard the partial OS; a held output SHALL be unaffected.

Reset
REQ-031 While reset=1, SHALL hold: state IDLE, fill counters 0, os_valid 0, os_data 0, os_type 0, os_len 0, os_lane_err 0, overflow 0.
REQ-032 Reset asserted mid-assembly SHALL discard the partial OS; after deassertion, assembly SHALL resume only on a new COM or block start.

Verification
REQ-033 With gen=1, LANES=16, SYM=4, active_lanes=2, a TS1 (BC,F7,F7,0F,00,02,4A...) starting at symbol 2 of a beat and os_ready=1 -> os_valid is a 1-cycle pulse 1 clock after the 5th beat, os_type=1, os_len=16, lanes 2..15 are zero.
REQ-034 With gen=1, one beat of BC,1C,1C,1C followed by BC,F7,... -> a SKP completes (os_len=4, os_type=3) and the next TS assembly starts in the following beat.
REQ-035 With gen=3, block_start=1, sync_hdr=01 and symbol 0 = 0x2D on all 4 active lanes -> os_type=2 after 4 beats; flipping lane 3's symbol 0 -> os_lane_err=1.
REQ-036 With os_ready=0 held across two completed ordered sets -> the first OS is held unchanged, overflow=1, the second OS is absent; os_ready=1 -> os_valid clears next cycle.
REQ-037 A COM at beat 2 of a 16-symbol OS -> no output for the partial OS, and the new OS completes 16 symbols after the new COM.
REQ-038 Reset pulsed during COLLECT -> all outputs are 0, and the next output appears only after a fresh COM.
